// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin merge of ALU/MUL/cache writeback FIFOs onto the single ROB write port
//   clock, reset (async, active-high), flush (sync drop of all buffered and output requests)
//   {alu,mul,cache}_req_valid/_info/_ready : producer push interfaces into private FIFOs
//   rob_ready : reorder buffer accepts the output stage this cycle
//   wb_req_valid/_info/_src : registered output stage (src 0=ALU, 1=MUL, 2=cache)
//   {alu,mul,cache}_fifo_cnt : per-source FIFO occupancy
package wb_port_arbiter_pkg;
    typedef struct packed {
        logic [4:0]  rob_id;
        logic [4:0]  dest;
        logic [31:0] value;
    } writeback_request_t;
endpackage

module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  alu_req_valid,
    input  writeback_request_t    alu_req_info,
    output logic                  alu_req_ready,
    input  logic                  mul_req_valid,
    input  writeback_request_t    mul_req_info,
    output logic                  mul_req_ready,
    input  logic                  cache_req_valid,
    input  writeback_request_t    cache_req_info,
    output logic                  cache_req_ready,
    input  logic                  rob_ready,
    output logic                  wb_req_valid,
    output writeback_request_t    wb_req_info,
    output logic [1:0]            wb_req_src,
    output logic [FIFO_CNT_W-1:0] alu_fifo_cnt,
    output logic [FIFO_CNT_W-1:0] mul_fifo_cnt,
    output logic [FIFO_CNT_W-1:0] cache_fifo_cnt
);
    localparam int PTR_W = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;

    writeback_request_t    mem [3][FIFO_DEPTH];
    writeback_request_t    in_info [3];
    logic [PTR_W-1:0]      rd_ptr [3];
    logic [PTR_W-1:0]      wr_ptr [3];
    logic [FIFO_CNT_W-1:0] cnt [3];
    logic [2:0]            in_valid, ready, nonempty, push, pop;
    logic [2:0]            cand;
    logic [1:0]            rr_last, grant_src;
    logic                  grant_any, load_en;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return p == PTR_W'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign in_valid   = {cache_req_valid, mul_req_valid, alu_req_valid};
    assign in_info[0] = alu_req_info;
    assign in_info[1] = mul_req_info;
    assign in_info[2] = cache_req_info;
    assign load_en    = !wb_req_valid || rob_ready;

    always_comb begin
        ready    = '0;
        nonempty = '0;
        push     = '0;
        pop      = '0;
        for (int i = 0; i < 3; i++) begin
            ready[i]    = cnt[i] != FIFO_CNT_W'(FIFO_DEPTH);
            nonempty[i] = cnt[i] != '0;
            push[i]     = in_valid[i] && ready[i] && !flush;
            pop[i]      = load_en && grant_any && grant_src == 2'(i) && !flush;
        end
    end

    // Walk candidates from farthest to nearest after rr_last so the nearest non-empty one wins.
    always_comb begin
        grant_any = 1'b0;
        grant_src = 2'd0;
        cand      = 3'd0;
        for (int k = 3; k >= 1; k--) begin
            cand = {1'b0, rr_last} + 3'(k);
            cand = cand >= 3'd3 ? cand - 3'd3 : cand;
            if (nonempty[cand[1:0]]) begin
                grant_any = 1'b1;
                grant_src = cand[1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < 3; i++)
            if (push[i]) mem[i][wr_ptr[i]] <= in_info[i];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset || flush) begin
            for (int i = 0; i < 3; i++) begin
                cnt[i]    <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push[i]) wr_ptr[i] <= inc(wr_ptr[i]);
                if (pop[i]) rd_ptr[i] <= inc(rd_ptr[i]);
                cnt[i] <= cnt[i] + FIFO_CNT_W'(push[i]) - FIFO_CNT_W'(pop[i]);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_req_valid <= 1'b0;
            wb_req_info  <= '0;
            wb_req_src   <= 2'd0;
            rr_last      <= 2'd2;
        end else if (flush) begin
            wb_req_valid <= 1'b0;
        end else if (load_en) begin
            wb_req_valid <= grant_any;
            if (grant_any) begin
                wb_req_info <= mem[grant_src][rd_ptr[grant_src]];
                wb_req_src  <= grant_src;
                rr_last     <= grant_src;
            end
        end
    end

    assign alu_req_ready   = ready[0];
    assign mul_req_ready   = ready[1];
    assign cache_req_ready = ready[2];
    assign alu_fifo_cnt    = cnt[0];
    assign mul_fifo_cnt    = cnt[1];
    assign cache_fifo_cnt  = cnt[2];
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               flush = 1'b0;
    logic               alu_req_valid = 1'b0, mul_req_valid = 1'b0, cache_req_valid = 1'b0;
    writeback_request_t alu_req_info = '0, mul_req_info = '0, cache_req_info = '0;
    logic               alu_req_ready, mul_req_ready, cache_req_ready;
    logic               rob_ready = 1'b0;
    logic               wb_req_valid;
    writeback_request_t wb_req_info;
    logic [1:0]         wb_req_src;
    logic [1:0]         alu_fifo_cnt, mul_fifo_cnt, cache_fifo_cnt;

    int checks = 0;
    int passed = 0;

    wb_port_arbiter #(.FIFO_DEPTH(2)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .alu_req_valid(alu_req_valid), .alu_req_info(alu_req_info), .alu_req_ready(alu_req_ready),
        .mul_req_valid(mul_req_valid), .mul_req_info(mul_req_info), .mul_req_ready(mul_req_ready),
        .cache_req_valid(cache_req_valid), .cache_req_info(cache_req_info), .cache_req_ready(cache_req_ready),
        .rob_ready(rob_ready), .wb_req_valid(wb_req_valid), .wb_req_info(wb_req_info),
        .wb_req_src(wb_req_src), .alu_fifo_cnt(alu_fifo_cnt), .mul_fifo_cnt(mul_fifo_cnt),
        .cache_fifo_cnt(cache_fifo_cnt)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        int exp_src [6];
        int exp_dest [6];
        int nid, eid;
        logic pushed;
        exp_src  = '{0, 1, 2, 0, 1, 2};
        exp_dest = '{0, 10, 20, 1, 11, 21};

        #12 reset = 1'b0;
        chk("rst_valid", wb_req_valid, 0);
        chk("rst_src", wb_req_src, 0);
        chk("rst_info", wb_req_info, 0);
        chk("rst_ready", {alu_req_ready, mul_req_ready, cache_req_ready}, 3'b111);
        chk("rst_cnt", {alu_fifo_cnt, mul_fifo_cnt, cache_fifo_cnt}, 0);

        // round robin: two pushes per source in the same two cycles
        rob_ready = 1'b1;
        {alu_req_valid, mul_req_valid, cache_req_valid} = 3'b111;
        alu_req_info.dest = 5'd0; mul_req_info.dest = 5'd10; cache_req_info.dest = 5'd20;
        tick();
        alu_req_info.dest = 5'd1; mul_req_info.dest = 5'd11; cache_req_info.dest = 5'd21;
        tick();
        {alu_req_valid, mul_req_valid, cache_req_valid} = 3'b000;
        chk("rr_cnt_after_fill", {alu_fifo_cnt, mul_fifo_cnt, cache_fifo_cnt}, {2'd1, 2'd2, 2'd2});
        for (int j = 0; j < 6; j++) begin
            chk("rr_valid", wb_req_valid, 1);
            chk("rr_src", wb_req_src, exp_src[j]);
            chk("rr_dest", wb_req_info.dest, exp_dest[j]);
            tick();
        end
        chk("rr_drained", wb_req_valid, 0);

        // single request
        alu_req_valid = 1'b1; alu_req_info = '0; alu_req_info.dest = 5'd5;
        tick();
        alu_req_valid = 1'b0;
        chk("single_cnt_e0", alu_fifo_cnt, 1);
        chk("single_valid_e0", wb_req_valid, 0);
        tick();
        chk("single_valid_e1", wb_req_valid, 1);
        chk("single_src", wb_req_src, 0);
        chk("single_dest", wb_req_info.dest, 5);
        chk("single_cnt_e1", alu_fifo_cnt, 0);
        tick();
        chk("single_valid_e2", wb_req_valid, 0);

        // backpressure on MUL
        rob_ready = 1'b0;
        mul_req_valid = 1'b1; mul_req_info = '0; mul_req_info.dest = 5'd1;
        tick();
        chk("bp_cnt1", mul_fifo_cnt, 1);
        mul_req_info.dest = 5'd2;
        tick();
        chk("bp_out_first", wb_req_info.dest, 1);
        chk("bp_src", wb_req_src, 1);
        mul_req_info.dest = 5'd3;
        tick();
        mul_req_valid = 1'b0;
        chk("bp_cnt_full", mul_fifo_cnt, 2);
        chk("bp_ready_low", mul_req_ready, 0);
        chk("bp_hold_dest", wb_req_info.dest, 1);
        tick();
        chk("bp_hold_valid", wb_req_valid, 1);
        chk("bp_hold_dest2", wb_req_info.dest, 1);
        chk("bp_hold_src", wb_req_src, 1);
        rob_ready = 1'b1;
        tick();
        chk("bp_second", wb_req_info.dest, 2);
        chk("bp_ready_after_pop", mul_req_ready, 1);
        chk("bp_cnt_after_pop", mul_fifo_cnt, 1);
        tick();
        chk("bp_third", wb_req_info.dest, 3);
        chk("bp_cnt_empty", mul_fifo_cnt, 0);
        tick();
        chk("bp_done", wb_req_valid, 0);

        // flush with output valid and one entry per FIFO
        rob_ready = 1'b0;
        alu_req_valid = 1'b1; alu_req_info.dest = 5'd7;
        tick();
        {alu_req_valid, mul_req_valid, cache_req_valid} = 3'b111;
        alu_req_info.dest = 5'd8; mul_req_info.dest = 5'd9; cache_req_info.dest = 5'd10;
        tick();
        {alu_req_valid, mul_req_valid} = 2'b00;
        chk("fl_pre_valid", wb_req_valid, 1);
        chk("fl_pre_dest", wb_req_info.dest, 7);
        chk("fl_pre_cnt", {alu_fifo_cnt, mul_fifo_cnt, cache_fifo_cnt}, {2'd1, 2'd1, 2'd1});
        flush = 1'b1; rob_ready = 1'b1; cache_req_info.dest = 5'd11;
        tick();
        flush = 1'b0; cache_req_valid = 1'b0;
        chk("fl_valid", wb_req_valid, 0);
        chk("fl_cnt", {alu_fifo_cnt, mul_fifo_cnt, cache_fifo_cnt}, 0);
        alu_req_valid = 1'b1; alu_req_info.dest = 5'd12;
        tick();
        alu_req_valid = 1'b0;
        chk("fl_post_cnt", alu_fifo_cnt, 1);
        rob_ready = 1'b0;
        tick();
        chk("fl_post_valid", wb_req_valid, 1);
        chk("fl_post_src", wb_req_src, 0);
        chk("fl_post_dest", wb_req_info.dest, 12);

        // asynchronous reset while the output is valid
        mul_req_valid = 1'b1; mul_req_info.dest = 5'd4;
        tick();
        mul_req_valid = 1'b0;
        chk("ar_pre_cnt", mul_fifo_cnt, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", wb_req_valid, 0);
        chk("ar_ready", {alu_req_ready, mul_req_ready, cache_req_ready}, 3'b111);
        chk("ar_cnt", {alu_fifo_cnt, mul_fifo_cnt, cache_fifo_cnt}, 0);
        #1 reset = 1'b0;
        tick();

        // wrap-around: ten cache ids through a toggling rob_ready
        nid = 0;
        eid = 0;
        cache_req_info = '0;
        for (int c = 0; c < 80 && eid < 10; c++) begin
            rob_ready = c[0];
            cache_req_valid = nid < 10;
            cache_req_info.rob_id = 5'(nid);
            if (wb_req_valid && rob_ready) begin
                chk("wrap_order", wb_req_info.rob_id, eid);
                eid++;
            end
            pushed = cache_req_valid && cache_req_ready;
            tick();
            if (pushed) nid++;
        end
        cache_req_valid = 1'b0;
        chk("wrap_count", eid, 10);
        rob_ready = 1'b1;
        tick();
        chk("wrap_empty", wb_req_valid, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
